// File: rtl/decode_reg_scoreboard.sv
// Register-read decode with a per-register outstanding-write scoreboard.
// Stalls issue on RAW/saturation hazards and registers read params in a valid/ready stage.
package decode_reg_pkg;
    localparam int REG_FIELD_W = 5;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic {
        CSR_SEL_REG = 1'b0,
        CSR_SEL_IMM = 1'b1
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e   input_select;
        logic [1:0] op;
    } sys_funct3_t;

    typedef struct packed {
        logic [6:0]             funct7;
        logic [REG_FIELD_W-1:0] rs2;
        logic [REG_FIELD_W-1:0] rs1;
        logic [2:0]             funct3;
        logic [REG_FIELD_W-1:0] rd;
    } r_instr_t;

    typedef struct packed {
        logic [11:0]            csr;
        logic [REG_FIELD_W-1:0] rs1;
        sys_funct3_t            funct3;
        logic [REG_FIELD_W-1:0] rd;
    } system_t;

    typedef union packed {
        r_instr_t r_instr;
        system_t  system;
    } instr_params_u;

    typedef struct packed {
        opcode_e       opcode;
        instr_params_u params;
    } instr_packet;

    typedef struct packed {
        logic [REG_FIELD_W-1:0] addr_rs1;
        logic [REG_FIELD_W-1:0] addr_rs2;
    } reg_file_read_params_t;
endpackage

module decode_reg_scoreboard
    import decode_reg_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int PEND_W    = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  instr_packet           instr,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output reg_file_read_params_t params,
    output logic [ADDR_W-1:0]     out_rd,
    output logic                  out_rd_we,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  wb_underflow
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic [ADDR_W-1:0] rs1_a, rs2_a, rd_a;
    logic [PEND_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
    logic              rs1_used, rs2_used, rd_we, csr_imm, is_lui;
    logic              bypass_rs1, bypass_rs2, hz_rs1, hz_rs2, hz_sat, src_hz;
    logic              accept;
    logic              unused_bits;

    assign unused_bits = ^instr.params.r_instr.funct7;

    always_comb begin
        csr_imm  = (instr.opcode == OPC_SYSTEM) &&
                   (instr.params.system.funct3.input_select == CSR_SEL_IMM);
        is_lui   = (instr.opcode == OPC_LUI);
        rs1_used = !(is_lui || instr.opcode == OPC_AUIPC || instr.opcode == OPC_JAL || csr_imm);
        rs2_used = (instr.opcode == OPC_OP) || (instr.opcode == OPC_STORE) ||
                   (instr.opcode == OPC_BRANCH);
        rs1_a    = (is_lui || csr_imm) ? '0 : ADDR_W'(instr.params.r_instr.rs1);
        rs2_a    = ADDR_W'(instr.params.r_instr.rs2);
        rd_a     = ADDR_W'(instr.params.r_instr.rd);
        rd_we    = 1'b0;
        case (instr.opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LOAD: rd_we = 1'b1;
            OPC_SYSTEM:                   rd_we = (instr.params.system.funct3 != '0);
            default:                      rd_we = 1'b0;
        endcase
        rd_we = rd_we && (rd_a != '0);
    end

    assign cnt_rs1 = cnt[rs1_a];
    assign cnt_rs2 = cnt[rs2_a];
    assign cnt_rd  = cnt[rd_a];

    // A writeback retiring the last pending write lets a dependent issue in the same cycle.
    assign bypass_rs1 = (WB_BYPASS != 0) && (cnt_rs1 == PEND_W'(1)) && wb_valid && (wb_addr == rs1_a);
    assign bypass_rs2 = (WB_BYPASS != 0) && (cnt_rs2 == PEND_W'(1)) && wb_valid && (wb_addr == rs2_a);
    assign hz_rs1     = rs1_used && (rs1_a != '0) && (cnt_rs1 != '0) && !bypass_rs1;
    assign hz_rs2     = rs2_used && (rs2_a != '0) && (cnt_rs2 != '0) && !bypass_rs2;
    assign hz_sat     = rd_we && (cnt_rd == CNT_MAX);
    assign src_hz     = hz_rs1 || hz_rs2 || hz_sat;

    assign in_ready = !src_hz && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        if (g == 0) begin : g_zero
            assign cnt[g] = '0;
        end else begin : g_reg
            logic [PEND_W-1:0] cnt_q;
            logic              inc, dec;

            assign inc = accept && rd_we && (rd_a == ADDR_W'(g));
            assign dec = wb_valid && (wb_addr == ADDR_W'(g)) && (cnt_q != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (inc && !dec) begin
                    cnt_q <= cnt_q + PEND_W'(1);
                end else if (dec && !inc) begin
                    cnt_q <= cnt_q - PEND_W'(1);
                end
            end

            assign cnt[g] = cnt_q;
        end
        assign busy_vec[g] = (cnt[g] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            params       <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            wb_underflow <= 1'b0;
        end else begin
            if (accept) begin
                out_valid       <= 1'b1;
                params.addr_rs1 <= REG_FIELD_W'(rs1_a);
                params.addr_rs2 <= REG_FIELD_W'(rs2_a);
                out_rd          <= rd_a;
                out_rd_we       <= rd_we;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
            if (wb_valid && (wb_addr != '0) && (cnt[wb_addr] == '0)) begin
                wb_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decode_reg_scoreboard.sv
// Directed bench for decode_reg_scoreboard: output stage checked by a queue-based monitor,
// hazard/counter behaviour checked inline; a second instance covers WB_BYPASS=0.
module tb_decode_reg_scoreboard;
    import decode_reg_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int PEND_W   = 2;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n, in_valid, in_valid_nb, flush, wb_valid, out_ready;
    logic [ADDR_W-1:0]     wb_addr;
    instr_packet           instr;
    logic                  in_ready, out_valid, out_rd_we, wb_underflow;
    reg_file_read_params_t params;
    logic [ADDR_W-1:0]     out_rd;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  nb_in_ready, nb_out_valid, nb_out_rd_we, nb_underflow;
    reg_file_read_params_t nb_params;
    logic [ADDR_W-1:0]     nb_out_rd;
    logic [NUM_REGS-1:0]   nb_busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   w;

    always #5 clk = ~clk;

    decode_reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PEND_W(PEND_W), .WB_BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid),
        .out_ready(out_ready), .params(params), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .busy_vec(busy_vec), .wb_underflow(wb_underflow)
    );

    decode_reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PEND_W(PEND_W), .WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_nb), .in_ready(nb_in_ready), .instr(instr),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(nb_out_valid),
        .out_ready(out_ready), .params(nb_params), .out_rd(nb_out_rd), .out_rd_we(nb_out_rd_we),
        .busy_vec(nb_busy), .wb_underflow(nb_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_packet mk_r(input opcode_e op, input int rd, input int rs1, input int rs2);
        instr_packet p;
        p = '0;
        p.opcode = op;
        p.params.r_instr.rd  = 5'(rd);
        p.params.r_instr.rs1 = 5'(rs1);
        p.params.r_instr.rs2 = 5'(rs2);
        return p;
    endfunction

    function automatic instr_packet mk_csr(input logic imm, input logic [1:0] op, input int rd, input int rs1f);
        instr_packet p;
        p = '0;
        p.opcode = OPC_SYSTEM;
        p.params.system.funct3.input_select = imm ? CSR_SEL_IMM : CSR_SEL_REG;
        p.params.system.funct3.op = op;
        p.params.system.rd  = 5'(rd);
        p.params.system.rs1 = 5'(rs1f);
        return p;
    endfunction

    function automatic exp_t mk_exp(input int rs1, input int rs2, input int rd, input logic we);
        exp_t e;
        e.rs1 = 5'(rs1);
        e.rs2 = 5'(rs2);
        e.rd  = 5'(rd);
        e.we  = we;
        return e;
    endfunction

    // Presents a packet from posedge+1 and waits (bounded) for acceptance.
    task automatic issue(input instr_packet p, input exp_t e, input int max_wait, output int waited);
        instr    = p;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < max_wait) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: out_rd=%0d with empty expectation queue", out_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_addr_rs1", 32'(params.addr_rs1), 32'(e.rs1));
                check("mon_addr_rs2", 32'(params.addr_rs2), 32'(e.rs2));
                check("mon_out_rd", 32'(out_rd), 32'(e.rd));
                check("mon_out_rd_we", 32'(out_rd_we), 32'(e.we));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid_nb = 1'b0; instr = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_params", 32'(params), 0);
        check("rst_out_rd", 32'(out_rd), 0);
        check("rst_out_rd_we", 32'(out_rd_we), 0);
        check("rst_busy_vec", busy_vec, 0);
        check("rst_underflow", 32'(wb_underflow), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        wb_valid = 1'b1; wb_addr = 5'd0;
        @(posedge clk); #1; wb_valid = 1'b0;
        check("wb_x0_ignored", 32'(wb_underflow), 0);

        issue(mk_r(OPC_OP, 3, 1, 2), mk_exp(1, 2, 3, 1'b1), 4, w);
        check("add_no_wait", w, 0);
        check("add_out_valid", 32'(out_valid), 1);
        check("add_busy_x3", busy_vec, 32'h0000_0008);
        @(posedge clk); #1;
        check("drain_out_valid", 32'(out_valid), 0);

        issue(mk_r(OPC_OP_IMM, 7, 0, 0), mk_exp(0, 0, 7, 1'b1), 4, w);
        issue(mk_r(OPC_OP_IMM, 9, 0, 0), mk_exp(0, 0, 9, 1'b1), 4, w);
        check("busy_3_7_9", busy_vec, 32'h0000_0288);

        issue(mk_r(OPC_LUI, 5, 7, 0), mk_exp(0, 0, 5, 1'b1), 4, w);
        check("lui_no_stall", w, 0);
        issue(mk_csr(1'b1, 2'b01, 6, 9), mk_exp(0, 0, 6, 1'b1), 4, w);
        check("csrrwi_no_stall", w, 0);
        check("busy_after_lui_csr", busy_vec, 32'h0000_02E8);

        // RAW on x3, released by a same-cycle writeback
        instr = mk_r(OPC_OP, 4, 3, 0); in_valid = 1'b1;
        @(negedge clk); check("raw_stall", 32'(in_ready), 0);
        @(posedge clk); #1; wb_valid = 1'b1; wb_addr = 5'd3;
        @(negedge clk); check("raw_bypass", 32'(in_ready), 1);
        if (in_ready) exp_q.push_back(mk_exp(3, 0, 4, 1'b1));
        @(posedge clk); #1; in_valid = 1'b0; wb_valid = 1'b0;
        check("busy_after_bypass", busy_vec, 32'h0000_02F0);

        // Saturate x8 (max 3 pending)
        for (int i = 0; i < 3; i++) issue(mk_r(OPC_OP_IMM, 8, 0, 0), mk_exp(0, 0, 8, 1'b1), 4, w);
        check("busy_x8_set", busy_vec, 32'h0000_03F0);
        instr = mk_r(OPC_OP_IMM, 8, 0, 0); in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check("sat_stall", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        wb_valid = 1'b1; wb_addr = 5'd8;
        @(negedge clk); check("sat_stall_with_wb", 32'(in_ready), 0);
        @(posedge clk); #1; wb_valid = 1'b0;
        @(negedge clk); check("sat_release", 32'(in_ready), 1);
        if (in_ready) exp_q.push_back(mk_exp(0, 0, 8, 1'b1));
        @(posedge clk); #1; in_valid = 1'b0;

        wb_valid = 1'b1; wb_addr = 5'd8;
        @(posedge clk); #1;
        issue(mk_r(OPC_OP_IMM, 8, 0, 0), mk_exp(0, 0, 8, 1'b1), 4, w);
        wb_valid = 1'b0;
        issue(mk_r(OPC_OP_IMM, 8, 0, 0), mk_exp(0, 0, 8, 1'b1), 4, w);
        check("refill_no_wait", w, 0);
        instr = mk_r(OPC_OP_IMM, 8, 0, 0); in_valid = 1'b1;
        @(negedge clk); check("simul_inc_dec_kept", 32'(in_ready), 0);
        @(posedge clk); #1; in_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd8;
        repeat (3) @(posedge clk);
        #1; wb_valid = 1'b0;
        check("x8_drained", busy_vec, 32'h0000_02F0);
        check("no_underflow_yet", 32'(wb_underflow), 0);
        check("queue_empty", exp_q.size(), 0);

        // Output hold, then flush
        out_ready = 1'b0;
        issue(mk_r(OPC_STORE, 14, 12, 13), mk_exp(12, 13, 14, 1'b0), 4, w);
        instr = mk_r(OPC_OP, 15, 1, 2); in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_rs1", 32'(params.addr_rs1), 12);
            check("hold_rs2", 32'(params.addr_rs2), 13);
            check("hold_rd", 32'(out_rd), 14);
            check("hold_rd_we", 32'(out_rd_we), 0);
            check("hold_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1; in_valid = ~in_valid;
        end
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk); check("flush_blocks_accept", 32'(in_ready), 0);
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_busy_kept", busy_vec, 32'h0000_02F0);
        out_ready = 1'b1;

        wb_valid = 1'b1; wb_addr = 5'd10;
        @(posedge clk); #1; wb_valid = 1'b0;
        check("underflow_set", 32'(wb_underflow), 1);
        check("underflow_busy", busy_vec, 32'h0000_02F0);
        repeat (3) @(posedge clk);
        #1;
        check("underflow_sticky", 32'(wb_underflow), 1);

        // Reset in the middle of a stall with a pending output
        out_ready = 1'b0;
        issue(mk_r(OPC_OP, 20, 1, 2), mk_exp(1, 2, 20, 1'b1), 4, w);
        instr = mk_r(OPC_OP, 21, 4, 0); in_valid = 1'b1;
        @(negedge clk); check("pre_reset_stall", 32'(in_ready), 0);
        #2; rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_params", 32'(params), 0);
        check("midrst_out_rd", 32'(out_rd), 0);
        check("midrst_rd_we", 32'(out_rd_we), 0);
        check("midrst_busy", busy_vec, 0);
        check("midrst_underflow", 32'(wb_underflow), 0);
        exp_q.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;

        // Without bypass the dependent issues one cycle after the writeback
        instr = mk_r(OPC_OP_IMM, 3, 0, 0); in_valid_nb = 1'b1;
        @(negedge clk); check("nb_first_ready", 32'(nb_in_ready), 1);
        @(posedge clk); #1; instr = mk_r(OPC_OP, 4, 3, 0);
        @(negedge clk); check("nb_raw_stall", 32'(nb_in_ready), 0);
        @(posedge clk); #1; wb_valid = 1'b1; wb_addr = 5'd3;
        @(negedge clk); check("nb_wb_same_cycle", 32'(nb_in_ready), 0);
        @(posedge clk); #1; wb_valid = 1'b0;
        @(negedge clk); check("nb_next_cycle", 32'(nb_in_ready), 1);
        @(posedge clk); #1; in_valid_nb = 1'b0;
        check("nb_busy_x4", nb_busy, 32'h0000_0010);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
